mem_io_responder: RTL and testbench

- Memory-side responder for the CPU's byte-serial RAM bus.
- Services the byte read and byte write requests issued by the memory controller on `mem_a` / `mem_dout` / `mem_wr`, and returns read bytes on `mem_din` one cycle later.
- Decodes a memory-mapped IO window containing:
  - a transmit FIFO, with back-pressure to the controller through `io_buffer_full`;
  - a receive holding register;
  - a simulation-done flag.

---
 rtl/mem_io_responder.sv | 144 ++++++++++++++
 tb/tb_mem_io_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Memory-side responder for the byte-serial RAM bus: byte RAM with one-cycle read latency plus
// an IO window holding a TX FIFO, an RX holding register and a simulation-done flag.
module mem_io_responder #(
   parameter int unsigned RAM_AW  = 17,
   parameter logic [31:0] IO_BASE = 32'h0003_0000,
   parameter int unsigned FIFO_AW = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic        io_tx_valid,
   output logic [7:0]  io_tx_data,
   input  logic        io_tx_ready,
   input  logic        io_rx_valid,
   input  logic [7:0]  io_rx_data,
   output logic        io_overflow,
   output logic        sim_done
);

   localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   CNT_FULL   = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0]   CNT_ALMOST = {1'b0, {FIFO_AW{1'b1}}};
   localparam logic [FIFO_AW:0]   CNT_ONE    = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [FIFO_AW-1:0] PTR_ONE    = {{(FIFO_AW-1){1'b0}}, 1'b1};

   logic [7:0]         r_ram [2**RAM_AW];
   logic [7:0]         r_ram_rd;
   logic               r_sel_ram;
   logic [7:0]         r_io_din;
   logic [7:0]         r_rx_data;
   logic               r_rx_full;
   logic [7:0]         r_fifo [FIFO_DEPTH];
   logic [FIFO_AW-1:0] r_rd_ptr;
   logic [FIFO_AW-1:0] r_wr_ptr;
   logic [FIFO_AW:0]   r_count;
   logic               r_buf_full;
   logic               r_overflow;
   logic               r_sim_done;

   logic               w_is_io;
   logic [31:0]        w_io_off;
   logic [RAM_AW-1:0]  w_ram_idx;
   logic               w_io_rd0;
   logic               w_io_rd4;
   logic               w_io_wr0;
   logic               w_io_wr4;
   logic               w_fifo_empty;
   logic               w_pop;
   logic               w_push;
   logic [FIFO_AW:0]   w_count_nxt;
   logic [7:0]         w_io_din;

   assign w_is_io   = (mem_a >= IO_BASE);
   assign w_io_off  = mem_a - IO_BASE;
   assign w_ram_idx = mem_a[RAM_AW-1:0];
   assign w_io_rd0  = w_is_io & ~mem_wr & (w_io_off == 32'd0);
   assign w_io_rd4  = w_is_io & ~mem_wr & (w_io_off == 32'd4);
   assign w_io_wr0  = w_is_io & mem_wr & (w_io_off == 32'd0);
   assign w_io_wr4  = w_is_io & mem_wr & (w_io_off == 32'd4);

   assign w_fifo_empty = (r_count == '0);
   assign w_pop        = ~w_fifo_empty & io_tx_ready;
   // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted.
   assign w_push       = w_io_wr0 & ((r_count < CNT_FULL) | w_pop);

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + CNT_ONE;
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - CNT_ONE;
      end
   end

   always_comb begin
      w_io_din = '0;
      if (w_io_rd0 && r_rx_full) begin
         w_io_din = r_rx_data;
      end else if (w_io_rd4) begin
         w_io_din = {6'b0, r_rx_full, w_fifo_empty};
      end
   end

   // Unreset storage; writes are suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (rst && mem_wr && !w_is_io) begin
         r_ram[w_ram_idx] <= mem_dout;
      end
      r_ram_rd <= r_ram[w_ram_idx];
      if (rst && w_push) begin
         r_fifo[r_wr_ptr] <= mem_dout;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sel_ram  <= 1'b0;
         r_io_din   <= '0;
         r_rx_data  <= '0;
         r_rx_full  <= 1'b0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_buf_full <= 1'b0;
         r_overflow <= 1'b0;
         r_sim_done <= 1'b0;
      end else begin
         r_sel_ram <= ~mem_wr & ~w_is_io;
         r_io_din  <= w_io_din;
         if (io_rx_valid) begin
            r_rx_data <= io_rx_data;
            r_rx_full <= 1'b1;
         end else if (w_io_rd0) begin
            r_rx_full <= 1'b0;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         r_count    <= w_count_nxt;
         r_buf_full <= (w_count_nxt >= CNT_ALMOST);
         if (w_io_wr0 && !w_push) begin
            r_overflow <= 1'b1;
         end
         if (w_io_wr4) begin
            r_sim_done <= 1'b1;
         end
      end
   end

   assign mem_din        = r_sel_ram ? r_ram_rd : r_io_din;
   assign io_buffer_full = r_buf_full;
   assign io_tx_valid    = ~w_fifo_empty;
   assign io_tx_data     = w_fifo_empty ? 8'h00 : r_fifo[r_rd_ptr];
   assign io_overflow    = r_overflow;
   assign sim_done       = r_sim_done;

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: a negedge reference model predicts every output and
// queues read responses; a separate monitor checks mem_din one cycle after each request.
module tb_mem_io_responder;

   localparam logic [31:0] IDLE_A = 32'h0003_000C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] mem_a = IDLE_A;
   logic [7:0]  mem_dout = 8'h00;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic        io_tx_valid;
   logic [7:0]  io_tx_data;
   logic        io_tx_ready = 1'b0;
   logic        io_rx_valid = 1'b0;
   logic [7:0]  io_rx_data = 8'h00;
   logic        io_overflow;
   logic        sim_done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit         chk;
      logic [7:0] val;
   } exp_t;

   exp_t       rd_q[$];
   logic [7:0] tx_q[$];
   logic [7:0] ram_m [int];
   logic       rxf_m  = 1'b0;
   logic [7:0] rxd_m  = 8'h00;
   logic       ovf_m  = 1'b0;
   logic       done_m = 1'b0;

   mem_io_responder dut (
      .clk            (clk),
      .rst            (rst),
      .mem_a          (mem_a),
      .mem_dout       (mem_dout),
      .mem_wr         (mem_wr),
      .mem_din        (mem_din),
      .io_buffer_full (io_buffer_full),
      .io_tx_valid    (io_tx_valid),
      .io_tx_data     (io_tx_data),
      .io_tx_ready    (io_tx_ready),
      .io_rx_valid    (io_rx_valid),
      .io_rx_data     (io_rx_data),
      .io_overflow    (io_overflow),
      .sim_done       (sim_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: outputs are compared against the state left by the last edge, then the
   // request visible on the bus is applied as the coming edge will.
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] off;
      bit          is_io;
      bit          pop;
      bit          push;
      bit          rd0;
      if (!rst) begin
         tx_q.delete();
         rxf_m  = 1'b0;
         ovf_m  = 1'b0;
         done_m = 1'b0;
      end
      chk("tx_valid", {7'b0, io_tx_valid}, {7'b0, tx_q.size() != 0});
      chk("tx_data", io_tx_data, (tx_q.size() != 0) ? tx_q[0] : 8'h00);
      chk("buffer_full", {7'b0, io_buffer_full}, {7'b0, tx_q.size() >= 7});
      chk("overflow", {7'b0, io_overflow}, {7'b0, ovf_m});
      chk("sim_done", {7'b0, sim_done}, {7'b0, done_m});
      e.chk = 1'b1;
      e.val = 8'h00;
      if (rst) begin
         is_io = (mem_a >= 32'h0003_0000);
         off   = mem_a - 32'h0003_0000;
         pop   = (tx_q.size() != 0) && io_tx_ready;
         push  = 1'b0;
         rd0   = 1'b0;
         if (mem_wr) begin
            if (!is_io) ram_m[int'(mem_a % 32'h0002_0000)] = mem_dout;
            else if (off == 0) begin
               if (tx_q.size() < 8 || pop) push = 1'b1;
               else ovf_m = 1'b1;
            end else if (off == 4) done_m = 1'b1;
         end else begin
            if (!is_io) begin
               if (ram_m.exists(int'(mem_a % 32'h0002_0000)))
                  e.val = ram_m[int'(mem_a % 32'h0002_0000)];
               else e.chk = 1'b0;
            end else if (off == 0) begin
               e.val = rxf_m ? rxd_m : 8'h00;
               rd0   = 1'b1;
            end else if (off == 4) e.val = {6'b0, rxf_m, tx_q.size() == 0};
         end
         if (io_rx_valid) begin
            rxf_m = 1'b1;
            rxd_m = io_rx_data;
         end else if (rd0) rxf_m = 1'b0;
         if (pop) void'(tx_q.pop_front());
         if (push) tx_q.push_back(mem_dout);
      end
      rd_q.push_back(e);
   end

   // Read-response monitor, decoupled from stimulus.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rd_q.size() != 0) begin
            e = rd_q.pop_front();
            if (e.chk) chk("mem_din", mem_din, e.val);
         end
      end
   end

   task automatic drive(input logic [31:0] a, input logic w, input logic [7:0] d);
      mem_a    = a;
      mem_wr   = w;
      mem_dout = d;
      @(posedge clk);
      #1;
      mem_a    = IDLE_A;
      mem_wr   = 1'b0;
      mem_dout = 8'h00;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(IDLE_A, 1'b0, 8'h00);
   endtask

   task automatic drain();
      io_tx_ready = 1'b1;
      for (int k = 0; k < 20 && io_tx_valid; k++) idle(1);
      chk("drain_done", {7'b0, io_tx_valid}, 8'h00);
   endtask

   initial begin
      logic [31:0] a;
      int          sel;
      logic [31:0] other_io [4];
      other_io[0] = 32'h0003_0008;
      other_io[1] = 32'h0003_0001;
      other_io[2] = 32'h0004_0000;
      other_io[3] = 32'hFFFF_FFFF;

      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      drive(32'h10, 1'b1, 8'hA5);
      drive(32'h10, 1'b0, 8'h00);

      for (int i = 0; i < 4; i++) drive(32'h100 + i, 1'b1, 8'h11 * (i + 1));
      for (int i = 0; i < 4; i++) drive(32'h100 + i, 1'b0, 8'h00);

      io_tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) drive(32'h0003_0000, 1'b1, 8'h41 + i);
      chk("tx_head_after_fill", io_tx_data, 8'h41);

      io_tx_ready = 1'b1;
      drive(32'h0003_0000, 1'b1, 8'h50);
      idle(3);
      io_tx_ready = 1'b0;

      io_rx_data  = 8'h7E;
      io_rx_valid = 1'b1;
      idle(1);
      io_rx_valid = 1'b0;
      drive(32'h0003_0000, 1'b0, 8'h00);
      drive(32'h0003_0000, 1'b0, 8'h00);
      drain();
      io_tx_ready = 1'b0;
      drive(32'h0003_0004, 1'b0, 8'h00);

      drive(32'h0003_0004, 1'b1, 8'hFF);
      idle(2);
      for (int i = 0; i < 4; i++) drive(32'h0003_0000, 1'b1, 8'h61 + i);
      io_tx_ready = 1'b1;
      idle(1);
      #1 rst = 1'b0;
      #1;
      chk("rst_mem_din", mem_din, 8'h00);
      chk("rst_buffer_full", {7'b0, io_buffer_full}, 8'h00);
      chk("rst_tx_valid", {7'b0, io_tx_valid}, 8'h00);
      chk("rst_tx_data", io_tx_data, 8'h00);
      chk("rst_overflow", {7'b0, io_overflow}, 8'h00);
      chk("rst_sim_done", {7'b0, sim_done}, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      io_tx_ready = 1'b0;
      drive(32'h10, 1'b0, 8'h00);
      drive(32'h2_0010, 1'b0, 8'h00);

      for (int n = 0; n < 600; n++) begin
         sel         = $urandom_range(0, 9);
         io_tx_ready = 1'($urandom_range(0, 1));
         io_rx_valid = ($urandom_range(0, 5) == 0);
         io_rx_data  = 8'($urandom);
         case (sel)
            0, 1, 2, 3: a = 32'($urandom_range(0, 63));
            4:          a = 32'h0002_0000 | 32'($urandom_range(0, 63));
            5, 6:       a = 32'h0003_0000;
            7:          a = 32'h0003_0004;
            8:          a = other_io[$urandom_range(0, 3)];
            default:    a = 32'h100 + 32'($urandom_range(0, 7));
         endcase
         drive(a, 1'($urandom_range(0, 1)), 8'($urandom));
      end
      io_rx_valid = 1'b0;
      drain();
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
